// File: rtl/data_memory_responder_if.sv
// Request/response channel between the MEM stage and the data memory responder.
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency doubleword memory responder for MEM-stage loads/stores.
// One response pulse per accepted request, LATENCY cycles after acceptance.
module data_memory_responder #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input logic                     clk,
  input logic                     reset,
  data_memory_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          write_q;
  logic [63:0]   addr_q;
  logic [63:0]   wdata_q;
  logic          resp_valid_q;
  logic [63:0]   resp_rdata_q;
  logic          resp_err_q;
  logic [63:0]   mem_q [DEPTH];

  logic          accept;
  logic          direct;
  logic          do_access;
  logic          acc_write;
  logic [63:0]   acc_addr;
  logic [63:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_err;

  always_comb begin
    bus.req_ready = (state_q != WAIT);
    accept        = bus.req_valid && bus.req_ready;
    // With single-cycle latency the access uses the live request at the accept edge.
    direct        = (LATENCY == 1) && accept;
    acc_write     = direct ? bus.req_write : write_q;
    acc_addr      = direct ? bus.req_addr  : addr_q;
    acc_wdata     = direct ? bus.req_wdata : wdata_q;
    do_access     = direct || ((state_q == WAIT) && (cnt_q == '0));
    acc_idx       = acc_addr[3 +: AW];
    // DEPTH is a power of two, so any set bit above the index means out of range.
    acc_err       = (|acc_addr[2:0]) || (|acc_addr[63:3+AW]);
    bus.stall     = (state_q == WAIT) || (bus.req_valid && !direct);
    bus.resp_valid = resp_valid_q;
    bus.resp_rdata = resp_rdata_q;
    bus.resp_err   = resp_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;

      if (do_access) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= acc_err;
        if (!acc_err && acc_write)  mem_q[acc_idx] <= acc_wdata;
        if (!acc_err && !acc_write) resp_rdata_q   <= mem_q[acc_idx];
      end

      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              cnt_q   <= CW'(LATENCY - 2);
              state_q <= WAIT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: LATENCY=2 and LATENCY=1 responders with hand-computed expectations.
module tb_data_memory_responder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  data_memory_responder_if bus2();
  data_memory_responder_if bus1();

  data_memory_responder #(.DEPTH(128), .LATENCY(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  data_memory_responder #(.DEPTH(128), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle on the LATENCY=2 responder: no response expected.
  task automatic idle2(input string tag);
    step();
    bus2.req_valid = 1'b0;
    #1;
    chk({tag, "_rv"},    64'(bus2.resp_valid), 64'd0);
    chk({tag, "_rdata"}, bus2.resp_rdata,      64'd0);
    chk({tag, "_stall"}, 64'(bus2.stall),      64'd0);
    chk({tag, "_ready"}, 64'(bus2.req_ready),  64'd1);
  endtask

  // Issue one request on the LATENCY=2 responder at the current cycle; returns in the response cycle.
  task automatic req2(input string tag, input logic w, input logic [63:0] a,
                      input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err);
    bus2.req_valid = 1'b1;
    bus2.req_write = w;
    bus2.req_addr  = a;
    bus2.req_wdata = wd;
    #1;
    chk({tag, "_acc_ready"}, 64'(bus2.req_ready), 64'd1);
    chk({tag, "_acc_stall"}, 64'(bus2.stall),     64'd1);
    step();
    bus2.req_valid = 1'b0;
    bus2.req_addr  = {$urandom, $urandom};
    bus2.req_wdata = {$urandom, $urandom};
    #1;
    chk({tag, "_wait_rv"},    64'(bus2.resp_valid), 64'd0);
    chk({tag, "_wait_stall"}, 64'(bus2.stall),      64'd1);
    chk({tag, "_wait_ready"}, 64'(bus2.req_ready),  64'd0);
    step();
    #1;
    chk({tag, "_rv"},    64'(bus2.resp_valid), 64'd1);
    chk({tag, "_rdata"}, bus2.resp_rdata,      exp_rd);
    chk({tag, "_err"},   64'(bus2.resp_err),   64'(exp_err));
    chk({tag, "_ready"}, 64'(bus2.req_ready),  64'd1);
  endtask

  logic [63:0] data1 [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_ready", 64'(bus2.req_ready),  64'd1);
    chk("rst_rv",    64'(bus2.resp_valid), 64'd0);
    chk("rst_rdata", bus2.resp_rdata,      64'd0);
    chk("rst_err",   64'(bus2.resp_err),   64'd0);
    chk("rst_stall", 64'(bus2.stall),      64'd0);
    chk("rst1_rv",   64'(bus1.resp_valid), 64'd0);

    idle2("idle_a");

    // Store then back-to-back load at 0x40, accepted in the RESP cycle.
    req2("st40", 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0);
    req2("ld40", 1'b0, 64'h40, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0);
    idle2("idle_b");

    req2("st00", 1'b1, 64'h0,   64'h01234567_89ABCDEF, 64'd0, 1'b0);
    req2("st3f8", 1'b1, 64'h3F8, 64'h77777777_00000001, 64'd0, 1'b0);
    req2("ld3f8", 1'b0, 64'h3F8, 64'h0, 64'h77777777_00000001, 1'b0);

    // Error cases: misaligned, just past the end, far out of range; none may write.
    req2("ld43",  1'b0, 64'h43,  64'h0, 64'd0, 1'b1);
    req2("ld400", 1'b0, 64'h400, 64'h0, 64'd0, 1'b1);
    req2("st41",  1'b1, 64'h41,  64'h55555555_55555555, 64'd0, 1'b1);
    req2("st400", 1'b1, 64'h400, 64'h66666666_66666666, 64'd0, 1'b1);
    req2("sthi",  1'b1, 64'h80000000_00000040, 64'h99999999_99999999, 64'd0, 1'b1);
    req2("ld40b", 1'b0, 64'h40, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0);
    req2("ld00",  1'b0, 64'h0,  64'h0, 64'h01234567_89ABCDEF, 1'b0);
    idle2("idle_c");

    // Store at 0x08 interrupted by reset before its access edge.
    req2("st08", 1'b1, 64'h08, 64'hA5A5A5A5_5A5A5A5A, 64'd0, 1'b0);
    idle2("idle_d");
    bus2.req_valid = 1'b1;
    bus2.req_write = 1'b1;
    bus2.req_addr  = 64'h08;
    bus2.req_wdata = 64'hBBBBBBBB_CCCCCCCC;
    step();
    bus2.req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rstmid_rv",    64'(bus2.resp_valid), 64'd0);
    chk("rstmid_ready", 64'(bus2.req_ready),  64'd1);
    chk("rstmid_stall", 64'(bus2.stall),      64'd0);
    idle2("idle_e");
    req2("ld08", 1'b0, 64'h08, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 1'b0);
    idle2("idle_f");

    // LATENCY=1: alternating store/load at 0x10 with req_valid held for 8 cycles.
    data1[0] = 64'h11110000_00000001;
    data1[1] = 64'h22220000_00000002;
    data1[2] = 64'h33330000_00000003;
    data1[3] = 64'h44440000_00000004;
    bus1.req_valid = 1'b1;
    bus1.req_write = 1'b1;
    bus1.req_addr  = 64'h10;
    bus1.req_wdata = data1[0];
    #1;
    chk("l1_stall_0", 64'(bus1.stall),     64'd0);
    chk("l1_ready_0", 64'(bus1.req_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("l1_rv_%0d", i),    64'(bus1.resp_valid), 64'd1);
      chk($sformatf("l1_err_%0d", i),   64'(bus1.resp_err),   64'd0);
      chk($sformatf("l1_rdata_%0d", i), bus1.resp_rdata,
          (i % 2 == 0) ? 64'd0 : data1[i/2]);
      if (i < 7) begin
        bus1.req_write = ((i + 1) % 2 == 0);
        bus1.req_wdata = ((i + 1) % 2 == 0) ? data1[(i+1)/2] : 64'hFFFFFFFF_FFFFFFFF;
      end else begin
        bus1.req_valid = 1'b0;
      end
      #1;
      chk($sformatf("l1_stall_%0d", i + 1), 64'(bus1.stall), 64'd0);
    end
    step();
    chk("l1_end_rv",    64'(bus1.resp_valid), 64'd0);
    chk("l1_end_rdata", bus1.resp_rdata,      64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
